conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
- Frame-level controller for the convolution + ReLU pipeline.
- On a host command it fetches one IMG_H x IMG_W 8-bit frame from a pixel memory and streams it, raster order, one pixel per cycle, into the engine.
- It writes every returned result into a result memory, counts results and signals frame completion or error to the host.
- Sits between the host/memory side and the conv+ReLU top.

Parameters:
- IMG_W, 32, frame width in pixels
- IMG_H, 32, frame height in pixels
- KSIZE, 3, kernel size; expected results = (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1)
- RES_W, 22, signed result width
- TIMEOUT, 4096, maximum cycles spent in DRAIN

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- host_start  in  1  frame request; sampled only in IDLE
- host_busy  out  1  high in every state except IDLE
- host_done  out  1  one-cycle pulse at frame end
- host_error  out  1  sticky; cleared on accepted host_start
- result_count  out  $clog2(IMG_W*IMG_H)+1  results received this frame (includes extras)
- pix_rd_en  out  1  pixel memory read strobe
- pix_rd_addr  out  $clog2(IMG_W*IMG_H)  pixel address
- pix_rd_data  in  8  read data, valid exactly 1 cycle after pix_rd_en
- eng_start  out  1  one-cycle start pulse to engine
- eng_pixel_valid  out  1  pixel strobe to engine
- eng_pixel_in  out  8  pixel to engine
- eng_result_in  in  RES_W signed  engine result
- eng_result_valid  in  1  result strobe
- eng_done  in  1  engine frame-done pulse
- res_wr_en  out  1  result memory write strobe
- res_wr_addr  out  $clog2(IMG_W*IMG_H)  result address
- res_wr_data  out  RES_W signed  result data

Behaviour:
- Clock/reset: one clock, clk; rst synchronous, active-high.
- Reset values:
  - FSM returns to IDLE.
  - All outputs 0, including host_error and result_count.
  - Internal done flag, counters and timeout cleared.
  - Applies mid-operation in any state; no write or done pulse follows.
- FSM states: IDLE, KICK, STREAM, DRAIN, DONE.
- IDLE:
  - host_start=1 -> KICK.
  - On this transition: clear result_count, host_error, done flag, pixel address counter.
- KICK:
  - eng_start=1 for exactly this cycle -> STREAM.
- STREAM:
  - pix_rd_en=1 every cycle, pix_rd_addr = 0,1,...,N-1 (N=IMG_W*IMG_H), no gaps.
  - After the cycle issuing address N-1 -> DRAIN.
  - STREAM lasts exactly N cycles.
- Pixel path:
  - eng_pixel_valid = pix_rd_en registered 1 cycle.
  - eng_pixel_in = pix_rd_data passed through combinationally.
  - Result: N contiguous valid cycles starting one cycle after first read; the last one occurs in the first DRAIN cycle.
- Result capture (every state except IDLE):
  - On eng_result_valid, if result_count < EXP: register res_wr_en=1, res_wr_addr=result_count, res_wr_data=eng_result_in (1-cycle latency), then increment result_count.
  - If result_count >= EXP: no write, result_count still increments, host_error set.
  - eng_result_valid in IDLE is ignored.
- Done flag:
  - eng_done in KICK, STREAM or DRAIN sets the internal done flag.
  - eng_done may arrive before, with or after the final result.
- DRAIN:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - Exit to DONE when done flag set AND result_count >= EXP. The check includes the result and done strobes arriving in the current cycle.
  - Timeout counter reaching TIMEOUT-1 -> DONE with host_error=1.
- DONE:
  - host_done=1 for this cycle, host_busy still 1 -> IDLE.
  - result_count and host_error hold until the next accepted host_start.
- host_start outside IDLE is ignored, with no effect on an ongoing frame.
- A write triggered by a result in the last DRAIN cycle still completes in the DONE cycle.

Test Plan:
Use IMG_W=IMG_H=5, KSIZE=3 (N=25, EXP=9), TIMEOUT=64, with a behavioural engine model.
1. Reset: assert rst 3 cycles mid-sim -> all outputs 0, host_busy=0; ten cycles of eng_result_valid in IDLE produce no res_wr_en.
2. Nominal frame: pixel memory holds data=addr+1; model returns 9 results (values -4..4) then pulses eng_done. Required:
   - eng_start pulses once, one cycle after host_start.
   - pix_rd_en high 25 consecutive cycles, addresses 0..24.
   - eng_pixel_valid high 25 consecutive cycles carrying 1..25.
   - Writes go to addresses 0..8 with matching signed data.
   - host_done pulses once, result_count=9, host_error=0.
3. Timeout: model returns 8 results and no eng_done -> host_done exactly 64 cycles after DRAIN entry; host_error=1, result_count=8.
4. Overflow and early done: model pulses eng_done during STREAM, then returns 10 results. Required:
   - Only 9 writes (addresses 0..8).
   - result_count=10, host_error=1.
   - host_done follows the 9th result.
5. Busy and back-to-back:
   - host_start pulsed during STREAM -> ignored; the frame still has exactly 25 reads.
   - A second host_start on the cycle after host_done -> a new frame with result_count and host_error cleared and result addresses restarting at 0.
6. Reset mid-STREAM at address 12 -> the next cycle has all outputs 0 in IDLE; a following host_start runs a full correct frame (as in scenario 2).

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Frame-level controller that sits in front of the convolution + ReLU engine.
// On a host request it kicks the engine, streams one IMG_H x IMG_W frame of
// 8-bit pixels from pixel memory in raster order (one pixel per cycle),
// stores every returned result in result memory, counts the results and
// reports frame completion (host_done) or an error (host_error).
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   host_start        : frame request, honoured only when idle
//   host_busy         : high whenever a frame is in progress
//   host_done         : one-cycle pulse at frame end
//   host_error        : sticky error (timeout or surplus results)
//   result_count      : results received this frame, surplus included
//   pix_rd_en/addr    : pixel memory read port request
//   pix_rd_data       : pixel memory data, one cycle after pix_rd_en
//   eng_start         : one-cycle engine start pulse
//   eng_pixel_valid/in: pixel stream into the engine
//   eng_result_in/valid, eng_done : results and frame-done from the engine
//   res_wr_en/addr/data: result memory write port
module conv_frame_sequencer #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int KSIZE   = 3,
    parameter int RES_W   = 22,
    parameter int TIMEOUT = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 host_start,
    output logic                                 host_busy,
    output logic                                 host_done,
    output logic                                 host_error,
    output logic [$clog2(IMG_W*IMG_H):0]         result_count,
    output logic                                 pix_rd_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]       pix_rd_addr,
    input  logic [7:0]                           pix_rd_data,
    output logic                                 eng_start,
    output logic                                 eng_pixel_valid,
    output logic [7:0]                           eng_pixel_in,
    input  logic signed [RES_W-1:0]              eng_result_in,
    input  logic                                 eng_result_valid,
    input  logic                                 eng_done,
    output logic                                 res_wr_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]       res_wr_addr,
    output logic signed [RES_W-1:0]              res_wr_data
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = AW + 1;
    localparam int EXP  = (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1);
    localparam int TW   = $clog2(TIMEOUT);

    localparam logic [CW-1:0] EXP_C    = CW'(EXP);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] ADDR_END = AW'(NPIX - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KICK   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]              state_q,   state_d;
    logic [AW-1:0]           addr_q,    addr_d;
    logic                    pvld_q;
    logic [CW-1:0]           cnt_q,     cnt_d;
    logic                    err_q,     err_d;
    logic                    done_q,    done_d;
    logic [TW-1:0]           to_q,      to_d;
    logic                    wr_en_q,   wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic signed [RES_W-1:0] wr_data_q, wr_data_d;
    logic                    engaged;

    assign engaged = (state_q == S_KICK) || (state_q == S_STREAM) || (state_q == S_DRAIN);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = done_q;
        to_d      = to_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Results are accepted in any busy state; surplus ones are counted
        // and flagged but never written past the expected result area.
        if (eng_result_valid && (state_q != S_IDLE)) begin
            if (cnt_q < EXP_C) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q[AW-1:0];
                wr_data_d = eng_result_in;
            end else begin
                err_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // eng_done can precede the final result, so it is latched.
        if (eng_done && engaged) begin
            done_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d = S_KICK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    addr_d  = '0;
                end
            end
            S_KICK: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (addr_q == ADDR_END) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    to_d    = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // done_d/cnt_d already include this cycle's strobes.
                if (done_d && (cnt_d >= EXP_C)) begin
                    state_d = S_DONE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pvld_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pvld_q    <= (state_q == S_STREAM);
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            to_q      <= to_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign host_busy       = (state_q != S_IDLE);
    assign host_done       = (state_q == S_DONE);
    assign host_error      = err_q;
    assign result_count    = cnt_q;
    assign pix_rd_en       = (state_q == S_STREAM);
    assign pix_rd_addr     = addr_q;
    assign eng_start       = (state_q == S_KICK);
    assign eng_pixel_valid = pvld_q;
    // Memory data is only meaningful alongside its valid strobe.
    assign eng_pixel_in    = pvld_q ? pix_rd_data : 8'd0;
    assign res_wr_en       = wr_en_q;
    assign res_wr_addr     = wr_addr_q;
    assign res_wr_data     = wr_data_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int K    = 3;
    localparam int RW   = 22;
    localparam int TO   = 64;
    localparam int N    = 25;
    localparam int EXPR = 9;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 host_start = 1'b0;
    logic                 host_busy, host_done, host_error;
    logic [CW-1:0]        result_count;
    logic                 pix_rd_en;
    logic [AW-1:0]        pix_rd_addr;
    logic [7:0]           pix_rd_data = 8'd0;
    logic                 eng_start, eng_pixel_valid;
    logic [7:0]           eng_pixel_in;
    logic signed [RW-1:0] eng_result_in = '0;
    logic                 eng_result_valid = 1'b0;
    logic                 eng_done = 1'b0;
    logic                 res_wr_en;
    logic [AW-1:0]        res_wr_addr;
    logic signed [RW-1:0] res_wr_data;

    conv_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .KSIZE(K), .RES_W(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .host_start(host_start),
        .host_busy(host_busy), .host_done(host_done), .host_error(host_error),
        .result_count(result_count),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .eng_start(eng_start), .eng_pixel_valid(eng_pixel_valid), .eng_pixel_in(eng_pixel_in),
        .eng_result_in(eng_result_in), .eng_result_valid(eng_result_valid), .eng_done(eng_done),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory: word at address a holds a+1, data one cycle after the read.
    always @(posedge clk) pix_rd_data <= pix_rd_en ? ({3'b000, pix_rd_addr} + 8'd1) : 8'd0;

    logic [52:0] outs;
    assign outs = {host_busy, host_done, host_error, result_count, pix_rd_en, pix_rd_addr,
                   eng_start, eng_pixel_valid, eng_pixel_in, res_wr_en, res_wr_addr, res_wr_data};

    // Event monitor, sampled on the falling edge; per-frame records restart on eng_start.
    int st_total = 0, hd_total = 0, wr_total = 0, st_cyc = 0;
    int rd_n = 0, rd_bad = 0, rd_first = 0, rd_last = 0;
    int pv_n = 0, pv_bad = 0, pv_first = 0, pv_last = 0;
    int wr_n = 0;
    logic [AW-1:0]        wr_addr [16];
    logic signed [RW-1:0] wr_data [16];

    always @(negedge clk) begin
        if (eng_start) begin
            st_total = st_total + 1;
            st_cyc = cyc;
            rd_n = 0; rd_bad = 0; pv_n = 0; pv_bad = 0; wr_n = 0;
        end
        if (pix_rd_en) begin
            if (rd_n == 0) rd_first = cyc;
            rd_last = cyc;
            if (int'(pix_rd_addr) != rd_n) rd_bad = rd_bad + 1;
            rd_n = rd_n + 1;
        end
        if (eng_pixel_valid) begin
            if (pv_n == 0) pv_first = cyc;
            pv_last = cyc;
            if (int'(eng_pixel_in) != pv_n + 1) pv_bad = pv_bad + 1;
            pv_n = pv_n + 1;
        end
        if (res_wr_en) begin
            wr_total = wr_total + 1;
            if (wr_n < 16) begin
                wr_addr[wr_n] = res_wr_addr;
                wr_data[wr_n] = res_wr_data;
            end
            wr_n = wr_n + 1;
        end
        if (host_done) hd_total = hd_total + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int st_base, hd_base;

    // Runs one frame from IDLE; returns in the DONE cycle (or after the bound).
    task automatic run_frame(input int nres, input bit early_done, input bit late_done,
                             input bit poke, output int lat, output int hs_cyc,
                             output longint kick_cnt, output longint kick_err);
        st_base = st_total;
        hd_base = hd_total;
        host_start = 1'b1;
        hs_cyc = cyc;
        step();
        host_start = 1'b0;
        kick_cnt = longint'(result_count);
        kick_err = longint'(host_error);
        step();
        for (int i = 0; i < N; i++) begin
            eng_done         = early_done && (i == 2);
            host_start       = poke && (i == 5);
            eng_result_valid = (i >= 10) && (i < 10 + nres);
            eng_result_in    = RW'(i - 14);
            step();
        end
        eng_done = 1'b0;
        host_start = 1'b0;
        eng_result_valid = 1'b0;
        lat = 0;
        while (!host_done && lat < 200) begin
            eng_done = late_done && (lat == 2);
            step();
            lat++;
        end
        eng_done = 1'b0;
    endtask

    task automatic check_nominal(input string p, input int lat, input int hs);
        chk({p, "_start_lat"}, st_cyc - hs, 1);
        chk({p, "_rd_n"}, rd_n, N);
        chk({p, "_rd_addr_bad"}, rd_bad, 0);
        chk({p, "_rd_span"}, rd_last - rd_first + 1, N);
        chk({p, "_pv_n"}, pv_n, N);
        chk({p, "_pv_data_bad"}, pv_bad, 0);
        chk({p, "_pv_span"}, pv_last - pv_first + 1, N);
        chk({p, "_pv_after_rd"}, pv_first - rd_first, 1);
        chk({p, "_wr_n"}, wr_n, EXPR);
        for (int k = 0; k < EXPR; k++) begin
            chk({p, "_wr_addr"}, longint'(wr_addr[k]), k);
            chk({p, "_wr_data"}, longint'(wr_data[k]), k - 4);
        end
        chk({p, "_done_lat"}, lat, 3);
        chk({p, "_count"}, longint'(result_count), EXPR);
        chk({p, "_error"}, longint'(host_error), 0);
        chk({p, "_done_busy"}, longint'({host_done, host_busy}), 3);
        step();
        chk({p, "_start_pulses"}, st_total - st_base, 1);
        chk({p, "_done_pulses"}, hd_total - hd_base, 1);
        chk({p, "_idle_busy"}, longint'({host_done, host_busy}), 0);
    endtask

    initial begin
        int lat, hs, wb, hb;
        longint kc, ke;

        // Power-on reset held for three cycles.
        rst = 1'b1;
        step(); step(); step();
        chk("por_outputs", longint'(outs), 0);
        rst = 1'b0;
        step();

        // Results arriving while idle are ignored.
        wb = wr_total;
        eng_result_in = RW'(7);
        for (int i = 0; i < 10; i++) begin
            eng_result_valid = 1'b1;
            step();
        end
        eng_result_valid = 1'b0;
        step();
        chk("idle_result_writes", wr_total - wb, 0);
        chk("idle_result_count", longint'(result_count), 0);

        // Nominal frame.
        run_frame(9, 1'b0, 1'b1, 1'b0, lat, hs, kc, ke);
        check_nominal("nom", lat, hs);

        // Timeout: 8 results, engine never reports done.
        run_frame(8, 1'b0, 1'b0, 1'b0, lat, hs, kc, ke);
        chk("to_done_lat", lat, TO);
        chk("to_error", longint'(host_error), 1);
        chk("to_count", longint'(result_count), 8);
        chk("to_wr_n", wr_n, 8);
        step();
        chk("to_hold_count", longint'(result_count), 8);
        chk("to_hold_error", longint'(host_error), 1);

        // Mid-simulation reset clears the sticky error and the count.
        rst = 1'b1;
        step(); step(); step();
        chk("mid_rst_outputs", longint'(outs), 0);
        rst = 1'b0;
        step();

        // Early done during STREAM, then ten results.
        run_frame(10, 1'b1, 1'b0, 1'b0, lat, hs, kc, ke);
        chk("ovf_wr_n", wr_n, EXPR);
        for (int k = 0; k < EXPR; k++) chk("ovf_wr_addr", longint'(wr_addr[k]), k);
        chk("ovf_count", longint'(result_count), 10);
        chk("ovf_error", longint'(host_error), 1);
        chk("ovf_done_lat", lat, 1);

        // Back-to-back start on the cycle after host_done, with a host_start
        // poke in the middle of STREAM.
        step();
        run_frame(9, 1'b0, 1'b1, 1'b1, lat, hs, kc, ke);
        chk("b2b_kick_count", kc, 0);
        chk("b2b_kick_error", ke, 0);
        check_nominal("b2b", lat, hs);

        // Reset while streaming address 12, with result and done strobes present.
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        step();
        for (int i = 0; i < 40 && pix_rd_addr != 5'd12; i++) begin
            eng_result_valid = (i >= 10);
            eng_result_in = RW'(i);
            step();
        end
        chk("mrs_reached_addr12", longint'(pix_rd_addr), 12);
        rst = 1'b1;
        eng_result_valid = 1'b1;
        eng_done = 1'b1;
        wb = wr_total;
        hb = hd_total;
        step();
        chk("mrs_outputs", longint'(outs), 0);
        rst = 1'b0;
        eng_result_valid = 1'b0;
        eng_done = 1'b0;
        step(); step(); step();
        chk("mrs_no_write", wr_total - wb, 0);
        chk("mrs_no_done", hd_total - hb, 0);

        run_frame(9, 1'b0, 1'b1, 1'b0, lat, hs, kc, ke);
        check_nominal("post_rst", lat, hs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
